// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the AXI master arbiter:
//   - arb_state_e : two-state address-channel FSM (ARB / HOLD)
//   - legal ranges for the master count and the write-order queue depth
//   - wrap_inc    : modulo increment used for round-robin and queue pointers
// -----------------------------------------------------------------------------
package axi_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int M_NUM_MIN    = 2;
  localparam int M_NUM_MAX    = 16;
  localparam int WQ_DEPTH_MIN = 2;
  localparam int WQ_DEPTH_MAX = 16;

  // Increment v modulo n; n need not be a power of two.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/axi_arb_picker.sv
// -----------------------------------------------------------------------------
// axi_arb_picker
// Combinational winner selection: the first asserted request found searching
// upward from i_ptr, wrapping past M_NUM-1 back to 0. With i_ptr tied to 0
// this degenerates to lowest-index-wins fixed priority.
// Ports:
//   i_req [M_NUM]   : request vector
//   i_ptr [M_WIDTH] : search start index (always < M_NUM)
//   o_idx [M_WIDTH] : winning index, 0 when nothing requests
//   o_any           : at least one request is asserted
// -----------------------------------------------------------------------------
module axi_arb_picker #(
  parameter  int M_NUM   = 3,
  localparam int M_WIDTH = $clog2(M_NUM)
) (
  input  logic [M_NUM-1:0]   i_req,
  input  logic [M_WIDTH-1:0] i_ptr,
  output logic [M_WIDTH-1:0] o_idx,
  output logic               o_any
);

  // One spare bit so ptr + offset cannot overflow before the wrap subtract.
  localparam int            CW    = M_WIDTH + 1;
  localparam logic [CW-1:0] NUM_C = CW'(M_NUM);

  logic [CW-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default before the search loop, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < M_NUM; k++) begin
      w_cand = {1'b0, i_ptr} + CW'(k);
      if (w_cand >= NUM_C) w_cand = w_cand - NUM_C;
      if (!o_any && i_req[w_cand[M_WIDTH-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[M_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rr_master_arbiter
// Address-channel arbiter for M_NUM AXI masters sharing one slave port.
//   AW / AR : two-state FSM each. In ARB the winner is combinational (0-cycle
//             latency); once a granted VALID stalls on !READY the winner is
//             locked (HOLD) until the handshake completes.
//   W       : a write-order queue records the AW winner on every AW handshake;
//             its head steers W and is popped on the W beat carrying LAST.
//   B / R   : destination index is the master field of the returned ID.
// Build option: define AXI_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (search starts one past the last handshaken master, per channel). Without
// it arbitration is fixed priority, lowest index wins.
// Ports:
//   clk, rstn                         : clock, synchronous active-low reset
//   MASTER_WR/RD_ADDR_VALID [M_NUM]   : per-master AW / AR requests
//   BUS_WR_ADDR_VALID/READY           : muxed AW handshake
//   BUS_WR_DATA_VALID/READY/LAST      : muxed W handshake
//   BUS_RD_ADDR_VALID/READY           : muxed AR handshake
//   BUS_WR/RD_BACK_ID                 : B / R channel IDs
//   wr/rd_addr_master_sel, _grant     : AW / AR source index and grant
//   wr_data_master_sel, _sel_valid    : W source index and its validity
//   wr_resp/rd_data_master_sel        : B / R destination index
//   wq_count                          : write-order queue occupancy
// -----------------------------------------------------------------------------
module axi_rr_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int M_ID     = 2,
  parameter  int M_NUM    = 3,
  parameter  int WQ_DEPTH = 4,
  localparam int M_WIDTH  = $clog2(M_NUM),
  localparam int WQ_CW    = $clog2(WQ_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [M_NUM-1:0]          MASTER_WR_ADDR_VALID,
  input  logic [M_NUM-1:0]          MASTER_RD_ADDR_VALID,
  input  logic                      BUS_WR_ADDR_VALID,
  input  logic                      BUS_WR_ADDR_READY,
  input  logic                      BUS_WR_DATA_VALID,
  input  logic                      BUS_WR_DATA_READY,
  input  logic                      BUS_WR_DATA_LAST,
  input  logic                      BUS_RD_ADDR_VALID,
  input  logic                      BUS_RD_ADDR_READY,
  input  logic [M_ID+M_WIDTH-1:0]   BUS_WR_BACK_ID,
  input  logic [M_ID+M_WIDTH-1:0]   BUS_RD_BACK_ID,
  output logic [M_WIDTH-1:0]        wr_addr_master_sel,
  output logic [M_WIDTH-1:0]        rd_addr_master_sel,
  output logic                      wr_addr_grant,
  output logic                      rd_addr_grant,
  output logic [M_WIDTH-1:0]        wr_data_master_sel,
  output logic                      wr_data_sel_valid,
  output logic [M_WIDTH-1:0]        wr_resp_master_sel,
  output logic [M_WIDTH-1:0]        rd_data_master_sel,
  output logic [WQ_CW-1:0]          wq_count
);

  if (M_NUM < M_NUM_MIN || M_NUM > M_NUM_MAX) begin : g_bad_m_num
    $error("axi_rr_master_arbiter: M_NUM out of range");
  end
  if (WQ_DEPTH < WQ_DEPTH_MIN || WQ_DEPTH > WQ_DEPTH_MAX) begin : g_bad_wq_depth
    $error("axi_rr_master_arbiter: WQ_DEPTH out of range");
  end

  localparam int               QPW     = $clog2(WQ_DEPTH);
  localparam logic [WQ_CW-1:0] WQ_FULL = WQ_CW'(WQ_DEPTH);

  arb_state_e         r_aw_state, r_ar_state;
  logic [M_WIDTH-1:0] r_aw_win, r_ar_win;
  logic [M_WIDTH-1:0] w_aw_pick, w_ar_pick, w_aw_ptr, w_ar_ptr;
  logic               w_aw_any, w_ar_any;
  logic               w_aw_hs, w_ar_hs;

  logic [M_WIDTH-1:0] r_wq_mem [WQ_DEPTH];
  logic [QPW-1:0]     r_wq_wr, r_wq_rd;
  logic [WQ_CW-1:0]   r_wq_count;
  logic               w_wq_empty, w_wq_full, w_push, w_pop, w_aw_blocked;

  // Low ID bits carry the master-local ID and are not needed here.
  logic w_unused_id;
  assign w_unused_id = ^{BUS_WR_BACK_ID, BUS_RD_BACK_ID};

  // ---------------------------------------------------------------- pickers
  axi_arb_picker #(.M_NUM(M_NUM)) u_aw_picker (
    .i_req (MASTER_WR_ADDR_VALID),
    .i_ptr (w_aw_ptr),
    .o_idx (w_aw_pick),
    .o_any (w_aw_any)
  );

  axi_arb_picker #(.M_NUM(M_NUM)) u_ar_picker (
    .i_req (MASTER_RD_ADDR_VALID),
    .i_ptr (w_ar_ptr),
    .o_idx (w_ar_pick),
    .o_any (w_ar_any)
  );

  // ------------------------------------------------------ write-order queue
  assign w_wq_empty = (r_wq_count == '0);
  assign w_wq_full  = (r_wq_count == WQ_FULL);
  assign w_pop      = BUS_WR_DATA_VALID && BUS_WR_DATA_READY && BUS_WR_DATA_LAST
                      && !w_wq_empty;
  assign w_push     = w_aw_hs;
  // A LAST beat retiring this cycle frees the slot the new AW needs, so a full
  // queue can still take an AW in the same cycle as a pop.
  assign w_aw_blocked = w_wq_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wq_wr    <= '0;
      r_wq_rd    <= '0;
      r_wq_count <= '0;
    end else begin
      if (w_push) r_wq_wr <= QPW'(wrap_inc(int'(r_wq_wr), WQ_DEPTH));
      if (w_pop)  r_wq_rd <= QPW'(wrap_inc(int'(r_wq_rd), WQ_DEPTH));
      case ({w_push, w_pop})
        2'b10:   r_wq_count <= r_wq_count + 1'b1;
        2'b01:   r_wq_count <= r_wq_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: queue storage has no reset; an entry is only ever read while the
  // occupancy count says it was written, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_wq_mem[r_wq_wr] <= wr_addr_master_sel;
  end

  assign wq_count           = r_wq_count;
  assign wr_data_sel_valid  = !w_wq_empty;
  assign wr_data_master_sel = w_wq_empty ? '0 : r_wq_mem[r_wq_rd];

  // ------------------------------------------------------ address channels
  assign wr_addr_master_sel = (r_aw_state == HOLD) ? r_aw_win : w_aw_pick;
  assign wr_addr_grant      = (r_aw_state == HOLD) ? 1'b1 : (w_aw_any && !w_aw_blocked);
  assign rd_addr_master_sel = (r_ar_state == HOLD) ? r_ar_win : w_ar_pick;
  assign rd_addr_grant      = (r_ar_state == HOLD) ? 1'b1 : w_ar_any;

  assign w_aw_hs = wr_addr_grant && BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY;
  assign w_ar_hs = rd_addr_grant && BUS_RD_ADDR_VALID && BUS_RD_ADDR_READY;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_aw_state <= ARB;
      r_aw_win   <= '0;
    end else begin
      case (r_aw_state)
        ARB:  if (wr_addr_grant && BUS_WR_ADDR_VALID && !BUS_WR_ADDR_READY) begin
                r_aw_state <= HOLD;
                r_aw_win   <= w_aw_pick;
              end
        HOLD: if (w_aw_hs) r_aw_state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ar_state <= ARB;
      r_ar_win   <= '0;
    end else begin
      case (r_ar_state)
        ARB:  if (rd_addr_grant && BUS_RD_ADDR_VALID && !BUS_RD_ADDR_READY) begin
                r_ar_state <= HOLD;
                r_ar_win   <= w_ar_pick;
              end
        HOLD: if (w_ar_hs) r_ar_state <= ARB;
      endcase
    end
  end

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [M_WIDTH-1:0] r_aw_ptr, r_ar_ptr;

  // The search restarts one past whoever completed the last handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_aw_ptr <= '0;
      r_ar_ptr <= '0;
    end else begin
      if (w_aw_hs) r_aw_ptr <= M_WIDTH'(wrap_inc(int'(wr_addr_master_sel), M_NUM));
      if (w_ar_hs) r_ar_ptr <= M_WIDTH'(wrap_inc(int'(rd_addr_master_sel), M_NUM));
    end
  end

  assign w_aw_ptr = r_aw_ptr;
  assign w_ar_ptr = r_ar_ptr;
`else
  assign w_aw_ptr = '0;
  assign w_ar_ptr = '0;
`endif

  // ------------------------------------------------------ response routing
  assign wr_resp_master_sel = BUS_WR_BACK_ID[M_ID +: M_WIDTH];
  assign rd_data_master_sel = BUS_RD_BACK_ID[M_ID +: M_WIDTH];

endmodule

// File: tb/tb_axi_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rr_master_arbiter
// Directed bench for axi_rr_master_arbiter (M_NUM=3, WQ_DEPTH=2, M_ID=2).
// A queue-based reference model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations. Honours
// AXI_ARB_ROUND_ROBIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_axi_rr_master_arbiter;

  localparam int M_ID     = 2;
  localparam int M_NUM    = 3;
  localparam int WQ_DEPTH = 2;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk, rstn;
  logic [2:0] MASTER_WR_ADDR_VALID, MASTER_RD_ADDR_VALID;
  logic       BUS_WR_ADDR_VALID, BUS_WR_ADDR_READY;
  logic       BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST;
  logic       BUS_RD_ADDR_VALID, BUS_RD_ADDR_READY;
  logic [3:0] BUS_WR_BACK_ID, BUS_RD_BACK_ID;
  logic [1:0] wr_addr_master_sel, rd_addr_master_sel;
  logic       wr_addr_grant, rd_addr_grant;
  logic [1:0] wr_data_master_sel;
  logic       wr_data_sel_valid;
  logic [1:0] wr_resp_master_sel, rd_data_master_sel;
  logic [1:0] wq_count;

  axi_rr_master_arbiter #(.M_ID(M_ID), .M_NUM(M_NUM), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .MASTER_WR_ADDR_VALID (MASTER_WR_ADDR_VALID),
    .MASTER_RD_ADDR_VALID (MASTER_RD_ADDR_VALID),
    .BUS_WR_ADDR_VALID    (BUS_WR_ADDR_VALID),
    .BUS_WR_ADDR_READY    (BUS_WR_ADDR_READY),
    .BUS_WR_DATA_VALID    (BUS_WR_DATA_VALID),
    .BUS_WR_DATA_READY    (BUS_WR_DATA_READY),
    .BUS_WR_DATA_LAST     (BUS_WR_DATA_LAST),
    .BUS_RD_ADDR_VALID    (BUS_RD_ADDR_VALID),
    .BUS_RD_ADDR_READY    (BUS_RD_ADDR_READY),
    .BUS_WR_BACK_ID       (BUS_WR_BACK_ID),
    .BUS_RD_BACK_ID       (BUS_RD_BACK_ID),
    .wr_addr_master_sel   (wr_addr_master_sel),
    .rd_addr_master_sel   (rd_addr_master_sel),
    .wr_addr_grant        (wr_addr_grant),
    .rd_addr_grant        (rd_addr_grant),
    .wr_data_master_sel   (wr_data_master_sel),
    .wr_data_sel_valid    (wr_data_sel_valid),
    .wr_resp_master_sel   (wr_resp_master_sel),
    .rd_data_master_sel   (rd_data_master_sel),
    .wq_count             (wq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // ------------------------------------------------------------ ref model
  // Lock = -1 means the channel is free to arbitrate; otherwise the master
  // whose stalled request must keep the channel. m_q lists masters whose AW
  // was accepted but whose last W beat has not yet been seen.
  int m_aw_lock, m_ar_lock, m_aw_ptr, m_ar_ptr;
  int m_q[$];
  bit m_valid = 1'b0;

  typedef struct {
    int aw_sel; int aw_g; int ar_sel; int ar_g;
    int wd_sel; int wd_v; int cnt;    int wr_resp; int rd_data;
  } exp_t;

  function automatic int pick(input logic [2:0] req, input int ptr);
    for (int k = 0; k < M_NUM; k++) begin
      int idx;
      idx = (ptr + k) % M_NUM;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic bit w_last_beat();
    return BUS_WR_DATA_VALID && BUS_WR_DATA_READY && BUS_WR_DATA_LAST;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    bit   pop;
    pop = w_last_beat() && (m_q.size() > 0);
    if (m_aw_lock >= 0) begin
      e.aw_sel = m_aw_lock; e.aw_g = 1;
    end else begin
      e.aw_sel = pick(MASTER_WR_ADDR_VALID, RR ? m_aw_ptr : 0);
      e.aw_g   = int'((MASTER_WR_ADDR_VALID != 0) && !(m_q.size() == WQ_DEPTH && !pop));
    end
    if (m_ar_lock >= 0) begin
      e.ar_sel = m_ar_lock; e.ar_g = 1;
    end else begin
      e.ar_sel = pick(MASTER_RD_ADDR_VALID, RR ? m_ar_ptr : 0);
      e.ar_g   = int'(MASTER_RD_ADDR_VALID != 0);
    end
    e.wd_v    = int'(m_q.size() > 0);
    e.wd_sel  = (m_q.size() > 0) ? m_q[0] : 0;
    e.cnt     = m_q.size();
    e.wr_resp = int'(BUS_WR_BACK_ID) / 4;
    e.rd_data = int'(BUS_RD_BACK_ID) / 4;
    return e;
  endfunction

  // Inputs change just after posedge, so values seen at negedge are exactly
  // what the next posedge samples: compare, then advance the model.
  always @(negedge clk) begin
    exp_t e;
    e = model_eval();
    if (m_valid) begin
      check("aw_sel",   int'(wr_addr_master_sel), e.aw_sel);
      check("aw_grant", int'(wr_addr_grant),      e.aw_g);
      check("ar_sel",   int'(rd_addr_master_sel), e.ar_sel);
      check("ar_grant", int'(rd_addr_grant),      e.ar_g);
      check("wd_sel",   int'(wr_data_master_sel), e.wd_sel);
      check("wd_valid", int'(wr_data_sel_valid),  e.wd_v);
      check("wq_count", int'(wq_count),           e.cnt);
      check("b_sel",    int'(wr_resp_master_sel), e.wr_resp);
      check("r_sel",    int'(rd_data_master_sel), e.rd_data);
      if (rstn && w_last_beat()) check("w_pop_nonempty", int'(m_q.size() > 0), 1);
    end
    if (!rstn) begin
      m_aw_lock = -1; m_ar_lock = -1; m_aw_ptr = 0; m_ar_ptr = 0;
      m_q.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (w_last_beat() && m_q.size() > 0) void'(m_q.pop_front());
      if (e.aw_g != 0 && BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY) begin
        m_q.push_back(e.aw_sel);
        m_aw_lock = -1;
        m_aw_ptr  = (e.aw_sel + 1) % M_NUM;
      end else if (e.aw_g != 0 && BUS_WR_ADDR_VALID) begin
        m_aw_lock = e.aw_sel;
      end
      if (e.ar_g != 0 && BUS_RD_ADDR_VALID && BUS_RD_ADDR_READY) begin
        m_ar_lock = -1;
        m_ar_ptr  = (e.ar_sel + 1) % M_NUM;
      end else if (e.ar_g != 0 && BUS_RD_ADDR_VALID) begin
        m_ar_lock = e.ar_sel;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    MASTER_WR_ADDR_VALID = '0; MASTER_RD_ADDR_VALID = '0;
    BUS_WR_ADDR_VALID = 0; BUS_WR_ADDR_READY = 0;
    BUS_WR_DATA_VALID = 0; BUS_WR_DATA_READY = 0; BUS_WR_DATA_LAST = 0;
    BUS_RD_ADDR_VALID = 0; BUS_RD_ADDR_READY = 0;
    BUS_WR_BACK_ID = '0; BUS_RD_BACK_ID = '0;
  endtask

  // Retire queued writes with single-beat bursts, gated by wr_data_sel_valid.
  task automatic drain();
    MASTER_WR_ADDR_VALID = '0; BUS_WR_ADDR_VALID = 0;
    for (int i = 0; i < 8 && wr_data_sel_valid; i++) begin
      BUS_WR_DATA_VALID = 1; BUS_WR_DATA_READY = 1; BUS_WR_DATA_LAST = 1;
      next();
    end
    BUS_WR_DATA_VALID = 0; BUS_WR_DATA_READY = 0; BUS_WR_DATA_LAST = 0;
    mid();
    check("drain_empty", int'(wr_data_sel_valid), 0);
    next();
  endtask

  int rr_order[4] = '{0, 1, 2, 0};

  initial begin
    idle();
    rstn = 0;
    next(); next();
    rstn = 1;
    mid();
    check("rst_aw_grant", int'(wr_addr_grant), 0);
    check("rst_ar_grant", int'(rd_addr_grant), 0);
    check("rst_aw_sel",   int'(wr_addr_master_sel), 0);
    check("rst_ar_sel",   int'(rd_addr_master_sel), 0);
    check("rst_wd_valid", int'(wr_data_sel_valid), 0);
    check("rst_wd_sel",   int'(wr_data_master_sel), 0);
    check("rst_wq_count", int'(wq_count), 0);
    next();

    // All three masters request; every AW accepted at once, W retires behind.
    MASTER_WR_ADDR_VALID = 3'b111; BUS_WR_ADDR_VALID = 1; BUS_WR_ADDR_READY = 1;
    for (int i = 0; i < 4; i++) begin
      BUS_WR_DATA_VALID = wr_data_sel_valid;
      BUS_WR_DATA_READY = 1; BUS_WR_DATA_LAST = 1;
      mid();
      check($sformatf("s1_order%0d", i), int'(wr_addr_master_sel), RR ? rr_order[i] : 0);
      check($sformatf("s1_grant%0d", i), int'(wr_addr_grant), 1);
      next();
    end
    drain();

    // Master 1 stalls 3 cycles while master 0 joins; lock holds, then 0 wins.
    MASTER_WR_ADDR_VALID = 3'b010; BUS_WR_ADDR_VALID = 1; BUS_WR_ADDR_READY = 0;
    mid(); check("s2_sel_c0", int'(wr_addr_master_sel), 1); next();
    MASTER_WR_ADDR_VALID = 3'b011;
    mid(); check("s2_sel_c1", int'(wr_addr_master_sel), 1); next();
    mid(); check("s2_sel_c2", int'(wr_addr_master_sel), 1); next();
    BUS_WR_ADDR_READY = 1;
    mid(); check("s2_sel_c3", int'(wr_addr_master_sel), 1); next();
    MASTER_WR_ADDR_VALID = 3'b001;
    mid();
    check("s2_next_sel",   int'(wr_addr_master_sel), 0);
    check("s2_next_grant", int'(wr_addr_grant), 1);
    next();
    mid();
    check("s2_count", int'(wq_count), 2);
    check("s2_head",  int'(wr_data_master_sel), 1);
    drain();

    // Queue fills with 2 then 0; a third AW is refused until 2's W retires.
    MASTER_WR_ADDR_VALID = 3'b100; BUS_WR_ADDR_VALID = 1; BUS_WR_ADDR_READY = 1;
    mid(); check("s3_sel_a", int'(wr_addr_master_sel), 2); next();
    MASTER_WR_ADDR_VALID = 3'b001;
    mid(); check("s3_sel_b", int'(wr_addr_master_sel), 0); next();
    MASTER_WR_ADDR_VALID = 3'b010;
    mid();
    check("s3_full_count", int'(wq_count), 2);
    check("s3_full_grant", int'(wr_addr_grant), 0);
    check("s3_full_head",  int'(wr_data_master_sel), 2);
    next();
    BUS_WR_DATA_VALID = 1; BUS_WR_DATA_READY = 1; BUS_WR_DATA_LAST = 1;
    BUS_WR_ADDR_READY = 0;
    mid(); next();
    BUS_WR_DATA_VALID = 0; BUS_WR_DATA_READY = 0; BUS_WR_DATA_LAST = 0;
    BUS_WR_ADDR_READY = 1;
    mid();
    check("s3_pop_count", int'(wq_count), 1);
    check("s3_pop_head",  int'(wr_data_master_sel), 0);
    check("s3_pop_grant", int'(wr_addr_grant), 1);
    check("s3_pop_sel",   int'(wr_addr_master_sel), 1);
    next();

    // Full queue [0,1]: pop and push in the same cycle.
    MASTER_WR_ADDR_VALID = 3'b100;
    BUS_WR_DATA_VALID = 1; BUS_WR_DATA_READY = 1; BUS_WR_DATA_LAST = 1;
    mid();
    check("s4_count_before", int'(wq_count), 2);
    check("s4_grant", int'(wr_addr_grant), 1);
    check("s4_sel",   int'(wr_addr_master_sel), 2);
    next();
    MASTER_WR_ADDR_VALID = '0; BUS_WR_ADDR_VALID = 0;
    mid();
    check("s4_count_after", int'(wq_count), 2);
    check("s4_head1", int'(wr_data_master_sel), 1);
    next();
    mid(); check("s4_head2", int'(wr_data_master_sel), 2); next();
    BUS_WR_DATA_VALID = 0; BUS_WR_DATA_READY = 0; BUS_WR_DATA_LAST = 0;
    mid(); check("s4_empty", int'(wr_data_sel_valid), 0); next();

    // Response routing from the master field of returned IDs.
    BUS_RD_BACK_ID = 4'b1011; BUS_WR_BACK_ID = 4'b0100;
    mid();
    check("id_r_1011", int'(rd_data_master_sel), 2);
    check("id_b_0100", int'(wr_resp_master_sel), 1);
    next();
    BUS_RD_BACK_ID = 4'b0111; BUS_WR_BACK_ID = 4'b0011;
    mid();
    check("id_r_0111", int'(rd_data_master_sel), 1);
    check("id_b_0011", int'(wr_resp_master_sel), 0);
    next();
    BUS_RD_BACK_ID = '0; BUS_WR_BACK_ID = '0;

    // AR channel: rotation, then a lock that ignores request changes.
    MASTER_RD_ADDR_VALID = 3'b111; BUS_RD_ADDR_VALID = 1; BUS_RD_ADDR_READY = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("ar_order%0d", i), int'(rd_addr_master_sel), RR ? rr_order[i] : 0);
      next();
    end
    MASTER_RD_ADDR_VALID = 3'b100; BUS_RD_ADDR_READY = 0;
    mid(); check("ar_hold_a", int'(rd_addr_master_sel), 2); next();
    MASTER_RD_ADDR_VALID = 3'b011;
    mid(); check("ar_hold_b", int'(rd_addr_master_sel), 2); next();
    BUS_RD_ADDR_READY = 1;
    MASTER_RD_ADDR_VALID = 3'b100;
    mid(); next();

    // Reset while AR is locked and the write queue is full.
    MASTER_RD_ADDR_VALID = 3'b010;
    mid(); next();
    MASTER_RD_ADDR_VALID = '0;
    MASTER_WR_ADDR_VALID = 3'b001; BUS_WR_ADDR_VALID = 1; BUS_WR_ADDR_READY = 1;
    next(); next();
    MASTER_WR_ADDR_VALID = 3'b010; BUS_WR_ADDR_READY = 0;
    MASTER_RD_ADDR_VALID = 3'b100; BUS_RD_ADDR_READY = 0;
    next();
    mid();
    check("r6_pre_count", int'(wq_count), 2);
    check("r6_pre_ar_sel", int'(rd_addr_master_sel), 2);
    check("r6_pre_aw_grant", int'(wr_addr_grant), 0);
    next();
    rstn = 0;
    mid(); next();
    rstn = 1;
    MASTER_WR_ADDR_VALID = '0; BUS_WR_ADDR_VALID = 0;
    MASTER_RD_ADDR_VALID = 3'b110;
    mid();
    check("r6_ar_sel",   int'(rd_addr_master_sel), 1);
    check("r6_ar_grant", int'(rd_addr_grant), 1);
    check("r6_count",    int'(wq_count), 0);
    check("r6_wd_valid", int'(wr_data_sel_valid), 0);
    check("r6_wd_sel",   int'(wr_data_master_sel), 0);
    next();

    idle();
    next(); next();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_rr_master_arbiter.md
AXI_RR_MASTER_ARBITER -- requirements
Module: axi_rr_master_arbiter

Interface
REQ-001 The block SHALL have parameter M_ID, default 2, meaning the number of master-local ID bits below the master index in bus IDs.
REQ-002 The block SHALL have parameter M_NUM, default 3, meaning the master count, legal range 2..16, not restricted to powers of two.
REQ-003 The block SHALL have parameter WQ_DEPTH, default 4, meaning the write-order queue depth, legal range 2..16.
REQ-004 The block SHALL have derived localparam M_WIDTH = $clog2(M_NUM), which is not overridable.
REQ-005 One clock, clk; reset is synchronous and active-low, rstn.
REQ-006 The block SHALL have ports clk (in, 1, clock) and rstn (in, 1, sync active-low reset).
REQ-007 The block SHALL have ports MASTER_WR_ADDR_VALID and MASTER_RD_ADDR_VALID (in, M_NUM each, per-master AW/AR requests).
REQ-008 The block SHALL have ports BUS_WR_ADDR_VALID/READY, BUS_WR_DATA_VALID/READY/LAST, BUS_RD_ADDR_VALID/READY (in, 1 each, muxed bus handshakes).
REQ-009 The block SHALL have ports BUS_WR_BACK_ID and BUS_RD_BACK_ID (in, M_ID+M_WIDTH each, B/R channel IDs).
REQ-010 The block SHALL have ports wr_addr_master_sel and rd_addr_master_sel (out, M_WIDTH each, AW/AR source index).
REQ-011 The block SHALL have ports wr_addr_grant and rd_addr_grant (out, 1 each); when an output is 0, the interconnect SHALL force the corresponding bus VALID and all master READYs to 0.
REQ-012 The block SHALL have ports wr_data_master_sel (out, M_WIDTH, W source index) and wr_data_sel_valid (out, 1, W select meaningful).
REQ-013 The block SHALL have ports wr_resp_master_sel and rd_data_master_sel (out, M_WIDTH each, B/R destination index).
REQ-014 The block SHALL have port wq_count (out, $clog2(WQ_DEPTH+1), write-order queue occupancy).

Function
REQ-015 wr_resp_master_sel SHALL equal BUS_WR_BACK_ID[M_ID+:M_WIDTH] combinationally, and rd_data_master_sel SHALL equal BUS_RD_BACK_ID[M_ID+:M_WIDTH] combinationally, with no lock.
REQ-016 Each address channel SHALL have a two-state FSM: ARB and HOLD.
REQ-017 In ARB, sel SHALL be the combinational winner among valid requests, and grant SHALL be 1 iff any request is valid (AW additionally requires !wq_full).
REQ-018 ARB SHALL transition to HOLD when grant && bus VALID && !READY, registering the winner.
REQ-019 In HOLD, sel SHALL be the registered winner, grant SHALL be 1, and a change in requests SHALL have no effect.
REQ-020 HOLD SHALL transition to ARB on the VALID && READY handshake.
REQ-021 A handshake SHALL be 0-cycle arbitration latency: grant and sel are valid in the same cycle that the request rises while in ARB.
REQ-022 The write-order queue SHALL push wr_addr_master_sel on every AW handshake.
REQ-023 The write-order queue SHALL pop on a W handshake with BUS_WR_DATA_LAST.
REQ-024 wr_data_master_sel SHALL be the queue head, and wr_data_sel_valid SHALL equal !empty.
REQ-025 When the queue is empty, wr_data_master_sel SHALL be 0.
REQ-026 When the queue is full, the AW channel SHALL not grant in ARB; an in-progress HOLD completes only because HOLD was entered with a free slot reserved.
REQ-027 Entering HOLD SHALL require !full.
REQ-028 A simultaneous push and pop SHALL leave wq_count unchanged and is legal when full.
REQ-029 Pop while empty SHALL be impossible, because the interconnect gates W by wr_data_sel_valid; the bench SHALL flag it.
REQ-030 Pointers SHALL wrap modulo WQ_DEPTH, and non-power-of-two depths SHALL be legal.
REQ-031 Request bits with index >= M_NUM SHALL not exist, and the computed sel SHALL never exceed M_NUM-1.

Reset
REQ-032 On clk edge with rstn=0, both FSMs SHALL go to ARB, the queue SHALL be emptied (wq_count=0), and the round-robin pointers and registered winners SHALL be set to 0.
REQ-033 After reset, outputs SHALL be: grants 0 with no requests, all sel 0, and wr_data_sel_valid 0.
REQ-034 Reset mid-burst SHALL discard all queued entries and locks; no state SHALL survive.

Configuration
REQ-035 With AXI_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first valid index searching upward from ptr, wrapping, where ptr = (last handshaken index + 1) mod M_NUM and is updated per channel on handshake only.
REQ-036 Without AXI_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with the lowest valid index winning, and the pointer logic SHALL be absent.

Structure
REQ-037 Package axi_arb_pkg SHALL hold the FSM state typedef (ARB/HOLD) and the M_NUM/WQ_DEPTH range-check constants.
REQ-038 Sub-module axi_arb_picker (requests, ptr -> winner index, any-valid) SHALL be instantiated for AW and AR.

Verification (M_NUM=3, WQ_DEPTH=2, round-robin on unless noted)
REQ-039 Scenario: requests 3'b111 held, every AW accepted in 1 cycle -> grant order 0,1,2,0; without the macro, 0,0,0,0.
REQ-040 Scenario: master 1 AW, READY low 3 cycles while master 0 rises -> sel stays 1 for 4 cycles, then 0 is granted next.
REQ-041 Scenario: AW from 2 then 0 with no W -> wq_count=2, third AW request sees wr_addr_grant=0; W LAST from 2 -> wq_count=1, sel becomes 0, AW granted.
REQ-042 Scenario: full queue with W LAST handshake and new AW handshake in the same cycle -> wq_count stays 2, order preserved.
REQ-043 Scenario: BUS_RD_BACK_ID=4'b1011 with M_ID=2 -> rd_data_master_sel=2; BUS_WR_BACK_ID=4'b0100 -> wr_resp_master_sel=1.
REQ-044 Scenario: rstn low during HOLD with wq_count=2 -> next cycle ARB, wq_count=0, wr_data_sel_valid=0, pointer 0.
